// File: rtl/led_step_controller.sv
// Four-position LED step sequencer driven by one push button: a short press reverses
// direction, a long press pauses/resumes. Button path is synchronized and debounced.
module led_step_controller #(
    parameter int STEP_CYCLES = 25_152_000,
    parameter int DEB_CYCLES  = 240_000,
    parameter int HOLD_CYCLES = 24_000_000
) (
    input  logic       clk_prescale,
    input  logic       rstn,
    input  logic       btn_a_n,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [1:0] step,
    output logic       dir,
    output logic       running
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = {HW{1'b1}};

    typedef enum logic [1:0] {
        REL     = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } press_state_t;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_level_reg;
    logic [DW-1:0] deb_cnt_reg;
    press_state_t  state_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic [TW-1:0] timer_reg;

    logic       deb_flip;
    logic       deb_press;
    logic       deb_release;
    logic       advance;
    logic [1:0] step_next;
    logic [2:0] led_next;

    // The press FSM reacts on the same edge the debounced level flips, so the
    // button-to-dir latency is the synchronizer plus the debounce window only.
    always_comb begin
        deb_flip    = (sync2_reg != deb_level_reg) && (deb_cnt_reg == DEB_LAST);
        deb_press   = deb_flip && !sync2_reg;
        deb_release = deb_flip && sync2_reg;
        advance     = running && (timer_reg == TIMER_LAST);
        step_next   = step;
        if (advance) begin
            step_next = dir ? (step - 2'd1) : (step + 2'd1);
        end
        case (step_next)
            2'd0:    led_next = 3'b111;
            2'd1:    led_next = 3'b011;
            2'd2:    led_next = 3'b101;
            default: led_next = 3'b110;
        endcase
    end

    always_ff @(posedge clk_prescale or negedge rstn) begin
        if (!rstn) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            deb_level_reg <= 1'b1;
            deb_cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_a_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_level_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                deb_level_reg <= sync2_reg;
                deb_cnt_reg   <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_prescale or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= REL;
            hold_cnt_reg <= '0;
            dir          <= 1'b0;
            running      <= 1'b1;
        end else begin
            case (state_reg)
                REL: begin
                    if (deb_press) begin
                        state_reg    <= PRESSED;
                        hold_cnt_reg <= '0;
                    end
                end
                PRESSED: begin
                    if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                    // A release wins over reaching the hold threshold on the same edge.
                    if (deb_release) begin
                        state_reg <= REL;
                        dir       <= ~dir;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= HELD;
                        running   <= ~running;
                    end
                end
                HELD: begin
                    if (deb_release) begin
                        state_reg <= REL;
                    end
                end
                default: state_reg <= REL;
            endcase
        end
    end

    // Step, timer and LEDs see the pre-edge dir/running, so coincident toggles
    // only take effect from the following edge.
    always_ff @(posedge clk_prescale or negedge rstn) begin
        if (!rstn) begin
            timer_reg <= '0;
            step      <= 2'd0;
            led_r     <= 1'b1;
            led_g     <= 1'b1;
            led_b     <= 1'b1;
        end else begin
            if (running) begin
                timer_reg <= (timer_reg == TIMER_LAST) ? '0 : (timer_reg + 1'b1);
            end
            step  <= step_next;
            led_r <= led_next[2];
            led_g <= led_next[1];
            led_b <= led_next[0];
        end
    end

endmodule
